pulp_pwr_domain_ctrl: RTL and testbench

- Parametrised power-domain sequencer. Replaces the hand-wired pairing of separate power-gating, isolation and clamp cells.
- Drives one switchable domain's power switch, clock enable, domain reset and an NUM_SIG-wide isolation bank with a per-bit clamp value.
- Uses a four-phase req/ack handshake with the always-on PMU, enforces minimum settle times, and detects switch-chain timeouts.
- Sits in the always-on domain at the boundary of each gated domain.

---
 rtl/pulp_pwr_domain_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pulp_pwr_domain_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulp_pwr_domain_ctrl.sv
// Power-domain sequencer for one switchable domain.
// Drives the power switch, clock gate, domain reset and the isolation clamp bank,
// and handshakes with the always-on PMU over a four-phase req/ack pair.
// Each power-up or power-down sequence runs to completion. The request is only
// re-examined once the domain is stable in ON or OFF.
module pulp_pwr_domain_ctrl #(
    parameter int                 NUM_SIG     = 32,
    parameter logic [NUM_SIG-1:0] ISO_VAL     = '0,
    parameter int                 PWR_UP_CYC  = 8,
    parameter int                 RST_CYC     = 4,
    parameter int                 ISO_CYC     = 2,
    parameter int                 TIMEOUT_CYC = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pwr_req_i,
    output logic               pwr_ack_o,
    output logic               err_o,
    output logic               sleep_o,
    input  logic               sleepout_i,
    output logic               clk_en_o,
    output logic               rst_dom_no,
    output logic               iso_o,
    input  logic [NUM_SIG-1:0] data_i,
    output logic [NUM_SIG-1:0] data_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] PWR_UP_LAST = CNT_W'(PWR_UP_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_CLK_EN = 3'd2,
        S_ON     = 3'd3,
        S_ISO    = 3'd4,
        S_RST    = 3'd5,
        S_PWR_DN = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // State, dwell counter and sticky timeout flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sequence steps and switch-chain timeout handling
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_OFF: begin
                if (pwr_req_i) begin
                    state_d = S_PWR_UP;
                    err_d   = 1'b0;
                end
            end
            S_PWR_UP: begin
                if (!sleepout_i && (cnt_q >= PWR_UP_LAST)) begin
                    state_d = S_CLK_EN;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_PWR_DN;
                    err_d   = 1'b1;
                end
            end
            S_CLK_EN: begin
                if (cnt_q == RST_LAST) state_d = S_ON;
            end
            S_ON: begin
                if (!pwr_req_i) state_d = S_ISO;
            end
            S_ISO: begin
                if (cnt_q == ISO_LAST) state_d = S_RST;
            end
            S_RST: begin
                if (cnt_q == RST_LAST) state_d = S_PWR_DN;
            end
            S_PWR_DN: begin
                if (sleepout_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_OFF;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Dwell counter: restarts on every state change, saturates when idle
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control outputs are decoded from registered state only. Ack is held low
    // in PWR_DN after a power-up timeout, because the domain never reached ON.
    always_comb begin
        sleep_o    = 1'b1;
        iso_o      = 1'b1;
        clk_en_o   = 1'b0;
        rst_dom_no = 1'b0;
        pwr_ack_o  = 1'b0;
        unique case (state_q)
            S_OFF: begin
            end
            S_PWR_UP: begin
                sleep_o = 1'b0;
            end
            S_CLK_EN: begin
                sleep_o  = 1'b0;
                clk_en_o = 1'b1;
            end
            S_ON: begin
                sleep_o    = 1'b0;
                iso_o      = 1'b0;
                clk_en_o   = 1'b1;
                rst_dom_no = 1'b1;
                pwr_ack_o  = 1'b1;
            end
            S_ISO: begin
                sleep_o    = 1'b0;
                clk_en_o   = 1'b1;
                rst_dom_no = 1'b1;
                pwr_ack_o  = 1'b1;
            end
            S_RST: begin
                sleep_o   = 1'b0;
                clk_en_o  = 1'b1;
                pwr_ack_o = 1'b1;
            end
            S_PWR_DN: begin
                pwr_ack_o = ~err_q;
            end
            default: begin
            end
        endcase
    end

    assign err_o  = err_q;
    assign data_o = iso_o ? ISO_VAL : data_i;

endmodule

// File: tb/tb_pulp_pwr_domain_ctrl.sv
// Directed bench for pulp_pwr_domain_ctrl with a cycle-stamped expectation queue.
// Each step drives the request and pushes the expected output vector for every
// following cycle. A monitor on the falling edge pops and compares those entries,
// and checks the isolation/reset/switch ordering rules on every cycle.
module tb_pulp_pwr_domain_ctrl;

    localparam logic [7:0] ISO_V = 8'hA5;
    localparam logic [7:0] DAT_V = 8'h3C;

    // Control fields in output order: sleep, iso, clk_en, rst_dom_n, ack
    localparam logic [4:0] C_OFF = 5'b11000;
    localparam logic [4:0] C_PU  = 5'b01000;
    localparam logic [4:0] C_CE  = 5'b01100;
    localparam logic [4:0] C_ON  = 5'b00111;
    localparam logic [4:0] C_ISO = 5'b01111;
    localparam logic [4:0] C_RST = 5'b01101;
    localparam logic [4:0] C_PD  = 5'b11001;
    localparam logic [4:0] C_PDE = 5'b11000;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       ack;
    logic       err;
    logic       sleep_o;
    logic       sleepout;
    logic       clk_en;
    logic       rst_dom_n;
    logic       iso;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       stuck;

    int ecnt   = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        string       tag;
        logic [13:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [13:0] obs;
    assign obs = {sleep_o, iso, clk_en, rst_dom_n, ack, err, data_o};

    pulp_pwr_domain_ctrl #(
        .NUM_SIG    (8),
        .ISO_VAL    (8'hA5),
        .PWR_UP_CYC (4),
        .RST_CYC    (2),
        .ISO_CYC    (3),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pwr_req_i (req),
        .pwr_ack_o (ack),
        .err_o     (err),
        .sleep_o   (sleep_o),
        .sleepout_i(sleepout),
        .clk_en_o  (clk_en),
        .rst_dom_no(rst_dom_n),
        .iso_o     (iso),
        .data_i    (data_i),
        .data_o    (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Switch chain returns sleep_o one cycle later unless held stuck open
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sleepout <= 1'b1;
        else        sleepout <= stuck ? 1'b1 : sleep_o;
    end

    task automatic check(input string tag, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bool(input string tag, input logic cond);
        checks++;
        assert (cond === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%b expected=1", tag, cond);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [4:0] ctl,
                        input logic e, input logic [7:0] d);
        exp_t x;
        x.at  = at;
        x.tag = tag;
        x.exp = {ctl, e, d};
        sb.push_back(x);
    endtask

    // Cycle k of a sequence is observed when ecnt == base + k - 1
    task automatic up_seq(input int base, input string tag);
        for (int k = 1; k <= 4; k++) push(base + k - 1, $sformatf("%s_pu_c%0d", tag, k), C_PU, 1'b0, ISO_V);
        for (int k = 5; k <= 6; k++) push(base + k - 1, $sformatf("%s_ce_c%0d", tag, k), C_CE, 1'b0, ISO_V);
        push(base + 6, $sformatf("%s_on_c7", tag), C_ON, 1'b0, DAT_V);
    endtask

    task automatic dn_seq(input int base, input string tag);
        for (int k = 1; k <= 3; k++) push(base + k - 1, $sformatf("%s_iso_c%0d", tag, k), C_ISO, 1'b0, ISO_V);
        for (int k = 4; k <= 5; k++) push(base + k - 1, $sformatf("%s_rst_c%0d", tag, k), C_RST, 1'b0, ISO_V);
        for (int k = 6; k <= 7; k++) push(base + k - 1, $sformatf("%s_pd_c%0d", tag, k), C_PD, 1'b0, ISO_V);
        push(base + 7, $sformatf("%s_off_c8", tag), C_OFF, 1'b0, ISO_V);
    endtask

    task automatic wait_to(input int t);
        @(negedge clk);
        while (ecnt < t) @(negedge clk);
    endtask

    // Scoreboard pop/compare plus ordering rules, sampled on the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= ecnt) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, mon_e.exp);
        end
        if (rst_n) begin
            check_bool("ord_iso_vs_rst", iso || rst_dom_n);
            check_bool("ord_rst_vs_sleep", !(rst_dom_n && sleep_o));
            check_bool("ord_clk_vs_sleep", !(clk_en && sleep_o));
        end
    end

    initial begin
        int base;
        int t;
        int n;

        rst_n  = 1'b0;
        req    = 1'b0;
        stuck  = 1'b0;
        data_i = DAT_V;

        #1 check("reset_state", {C_OFF, 1'b0, ISO_V});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        push(ecnt + 1, "idle_1", C_OFF, 1'b0, ISO_V);
        push(ecnt + 2, "idle_2", C_OFF, 1'b0, ISO_V);
        wait_to(ecnt + 2);

        // Nominal power-up, then hold in ON
        req  = 1'b1;
        base = ecnt + 1;
        up_seq(base, "up");
        push(base + 7, "up_hold_c8", C_ON, 1'b0, DAT_V);
        wait_to(base + 7);

        // Nominal power-down
        req  = 1'b0;
        base = ecnt + 1;
        dn_seq(base, "dn");
        push(base + 8, "dn_hold_c9", C_OFF, 1'b0, ISO_V);
        wait_to(base + 8);

        // Request pulse that falls before any rising edge sees it
        t = ecnt;
        #1 req = 1'b1;
        #2 req = 1'b0;
        for (int k = 1; k <= 3; k++) push(t + k, $sformatf("pulse_off_%0d", k), C_OFF, 1'b0, ISO_V);
        wait_to(t + 3);

        // Switch chain stuck open: timeout, back to OFF with err set and ack low
        stuck = 1'b1;
        req   = 1'b1;
        base  = ecnt + 1;
        for (int k = 1; k <= 16; k++) push(base + k - 1, $sformatf("stuck_pu_c%0d", k), C_PU, 1'b0, ISO_V);
        push(base + 16, "stuck_pd_c17", C_PDE, 1'b1, ISO_V);
        push(base + 17, "stuck_off_c18", C_OFF, 1'b1, ISO_V);
        push(base + 18, "stuck_off_c19", C_OFF, 1'b1, ISO_V);
        wait_to(base + 2);
        req = 1'b0;
        wait_to(base + 18);

        // Switch released: next request clears err and powers up normally
        stuck = 1'b0;
        req   = 1'b1;
        base  = ecnt + 1;
        up_seq(base, "rec");
        wait_to(base + 6);
        req  = 1'b0;
        base = ecnt + 1;
        dn_seq(base, "rec_dn");
        wait_to(base + 7);

        // Request withdrawn during CLK_EN: reach ON, then leave on the next cycle
        req  = 1'b1;
        base = ecnt + 1;
        up_seq(base, "gl");
        wait_to(base + 4);
        req = 1'b0;
        dn_seq(base + 7, "gl_dn");
        wait_to(base + 14);

        // Asynchronous reset while ON forces OFF outputs without a clock edge
        req  = 1'b1;
        base = ecnt + 1;
        up_seq(base, "ar");
        wait_to(base + 6);
        #2 rst_n = 1'b0;
        req = 1'b0;
        #1 check("async_rst_off", {C_OFF, 1'b0, ISO_V});
        @(negedge clk);
        rst_n = 1'b1;

        // Random request traffic; ordering rules are checked every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req = ~req;
            if ($urandom_range(0, 3) == 0) data_i = 8'($urandom);
        end
        data_i = DAT_V;
        req    = 1'b0;
        n      = 0;
        while (!(sleep_o && !ack) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_bool("drain_to_off", sleep_o && !ack);
        push(ecnt + 1, "final_off_1", C_OFF, 1'b0, ISO_V);
        push(ecnt + 2, "final_off_2", C_OFF, 1'b0, ISO_V);
        wait_to(ecnt + 2);

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_bool("scoreboard_empty", sb.size() == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
